// File: rtl/control_cadena_tx.sv
// control_cadena_tx: serial transmit sequencer that frames a word as SYNC + LSB-first data + EOP.
// Optional BIT_STUFF_EN inserts a 0 after six consecutive transmitted 1s.
module control_cadena_tx #(
    parameter int DATA_W = 32,
    parameter int DIV = 4,
    parameter int SYNC_W = 8,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 8'h80,
    parameter int EOP_LEN = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] dato_entrada,
    input  logic              inicio,
    output logic              listo,
    output logic              dato_sal,
    output logic              sal_en,
    output logic              ocupado,
    output logic              fin
);
    localparam int CW = $clog2(DATA_W + SYNC_W + EOP_LEN);
    localparam int DW = $clog2(DIV + 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
`ifdef BIT_STUFF_EN
        STUFF,
`endif
        EOP
    } state_t;

    state_t state, state_n;
    logic [DW-1:0] div_cnt, div_n;
    logic [CW-1:0] bit_cnt, bit_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic [SYNC_W-1:0] sy, sy_n;
    logic bit_end;
`ifdef BIT_STUFF_EN
    logic [2:0] ones, ones_n;
    state_t ret, ret_n;
`endif

    always_comb begin
        bit_end = state != IDLE && div_cnt == DW'(DIV - 1);
        state_n = state;
        div_n = div_cnt;
        bit_n = bit_cnt;
        sh_n = sh;
        sy_n = sy;
`ifdef BIT_STUFF_EN
        ones_n = ones;
        ret_n = ret;
`endif
        if (state == IDLE) begin
            div_n = '0;
            bit_n = '0;
`ifdef BIT_STUFF_EN
            ones_n = '0;
`endif
            if (inicio) begin
                state_n = SYNC;
                sh_n = dato_entrada;
                sy_n = SYNC_PAT;
            end
        end else begin
            div_n = bit_end ? '0 : div_cnt + 1'b1;
            if (bit_end) begin
                bit_n = bit_cnt + 1'b1;
                case (state)
                    SYNC: begin
                        sy_n = sy >> 1;
                        if (bit_cnt == CW'(SYNC_W - 1)) begin
                            state_n = DATA;
                            bit_n = '0;
                        end
                    end
                    DATA: begin
                        sh_n = sh >> 1;
                        if (bit_cnt == CW'(DATA_W - 1)) begin
                            state_n = EOP;
                            bit_n = '0;
                        end
                    end
                    EOP: begin
                        if (bit_cnt == CW'(EOP_LEN - 1)) begin
                            state_n = IDLE;
                            bit_n = '0;
                        end
                    end
                    default: ;
                endcase
`ifdef BIT_STUFF_EN
                // The stuff bit takes a bit-time but does not advance the frame position.
                if (state == STUFF) begin
                    state_n = ret;
                    bit_n = bit_cnt;
                end else if (state != EOP) begin
                    ones_n = dato_sal ? ones + 3'd1 : '0;
                    if (ones_n == 3'd6) begin
                        ret_n = state_n;
                        state_n = STUFF;
                        ones_n = '0;
                    end
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            sh <= '0;
            sy <= '0;
            dato_sal <= 1'b1;
            sal_en <= 1'b0;
            listo <= 1'b1;
            ocupado <= 1'b0;
            fin <= 1'b0;
`ifdef BIT_STUFF_EN
            ones <= '0;
            ret <= IDLE;
`endif
        end else begin
            state <= state_n;
            div_cnt <= div_n;
            bit_cnt <= bit_n;
            sh <= sh_n;
            sy <= sy_n;
            dato_sal <= state_n == IDLE || (state_n == SYNC && sy_n[0]) || (state_n == DATA && sh_n[0]);
            sal_en <= state_n != IDLE;
            listo <= state_n == IDLE;
            ocupado <= state_n != IDLE;
            fin <= state == EOP && state_n == IDLE;
`ifdef BIT_STUFF_EN
            ones <= ones_n;
            ret <= ret_n;
`endif
        end
    end
endmodule

// File: tb/tb_control_cadena_tx.sv
// tb_control_cadena_tx: directed checks of control_cadena_tx at DIV=4 and DIV=1.
module tb_control_cadena_tx;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [31:0] din = '0, b_din = '0;
    logic inicio = 1'b0, b_inicio = 1'b0;
    logic listo, dato_sal, sal_en, ocupado, fin;
    logic b_listo, b_dato_sal, b_sal_en, b_ocupado, b_fin;
    int checks = 0, errors = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    control_cadena_tx #(.DIV(4)) u_a (
        .clk(clk), .reset(reset), .dato_entrada(din), .inicio(inicio), .listo(listo),
        .dato_sal(dato_sal), .sal_en(sal_en), .ocupado(ocupado), .fin(fin)
    );

    control_cadena_tx #(.DIV(1)) u_b (
        .clk(clk), .reset(reset), .dato_entrada(b_din), .inicio(b_inicio), .listo(b_listo),
        .dato_sal(b_dato_sal), .sal_en(b_sal_en), .ocupado(b_ocupado), .fin(b_fin)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line bits of one frame, one entry per bit-time.
    task automatic build(input logic [31:0] w);
        logic [7:0] sp;
        logic b;
`ifdef BIT_STUFF_EN
        int ones;
        ones = 0;
`endif
        sp = 8'h80;
        exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            b = i < 8 ? sp[i] : w[i-8];
            exp_q.push_back(b);
`ifdef BIT_STUFF_EN
            ones = b ? ones + 1 : 0;
            if (ones == 6) begin
                exp_q.push_back(1'b0);
                ones = 0;
            end
`endif
        end
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
    endtask

    // Sends w on the DIV=4 instance; returns in the fin cycle without advancing past it.
    task automatic frame_a(input logic [31:0] w, input int len, input int busy_at, input logic [31:0] w2);
        int k;
        build(w);
        din = w;
        inicio = 1'b1;
        tick;
        inicio = 1'b0;
        din = '0;
        chk("listo low in frame", listo, 0);
        for (int c = 1; c <= len; c++) begin
            if (c == busy_at) begin
                inicio = 1'b1;
                din = w2;
            end
            k = (c - 1) / 4;
            chk($sformatf("sal_en c%0d", c), sal_en, 1);
            chk($sformatf("dato_sal c%0d", c), dato_sal, k < exp_q.size() ? exp_q[k] : 1'b0);
            tick;
        end
        chk("fin pulse", fin, 1);
        chk("sal_en after frame", sal_en, 0);
        chk("listo after frame", listo, 1);
        chk("ocupado after frame", ocupado, 0);
        chk("idle line", dato_sal, 1);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        inicio = 1'b1;
        din = 32'hDEADBEEF;
        repeat (3) tick;
        chk("rst dato_sal", dato_sal, 1);
        chk("rst sal_en", sal_en, 0);
        chk("rst listo", listo, 1);
        chk("rst ocupado", ocupado, 0);
        chk("rst fin", fin, 0);
        chk("rst b listo", b_listo, 1);
        reset = 1'b0;
        inicio = 1'b0;
        tick;
        chk("no accept in reset", sal_en, 0);
        chk("still listo", listo, 1);

        frame_a(32'hA5A55A5A, 168, 0, '0);
        tick;
        chk("fin one cycle", fin, 0);
        chk("idle sal_en", sal_en, 0);

        frame_a(32'h0F0F3C3C, 168, 20, 32'hFFFF0000);
        tick;
        inicio = 1'b0;
        chk("second start sal_en", sal_en, 1);
        chk("second sync bit0", dato_sal, 0);
        chk("second fin low", fin, 0);
        repeat (49) tick;
        chk("second c50 sal_en", sal_en, 1);
        chk("second c50 data bit4", dato_sal, 0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("midrst sal_en", sal_en, 0);
        chk("midrst listo", listo, 1);
        chk("midrst dato_sal", dato_sal, 1);
        chk("midrst ocupado", ocupado, 0);
        chk("midrst fin", fin, 0);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("no fin after abort", fin, 0);
        end

`ifdef BIT_STUFF_EN
        frame_a(32'h0000003F, 172, 0, '0);
`else
        frame_a(32'h0000003F, 168, 0, '0);
`endif
        tick;
        chk("stuff fin low", fin, 0);

        b_din = 32'h12345678;
        b_inicio = 1'b1;
        tick;
        build(32'h12345678);
        n = 0;
        while (b_sal_en && n < 100) begin
            chk($sformatf("b1 bit%0d", n), b_dato_sal, n < exp_q.size() ? exp_q[n] : 1'b0);
            n++;
            tick;
        end
        chk("b1 length", n, 42);
        chk("b1 fin", b_fin, 1);
        chk("b1 gap sal_en", b_sal_en, 0);
        chk("b1 gap listo", b_listo, 1);
        b_din = 32'h0000AAAA;
        tick;
        chk("b2 starts", b_sal_en, 1);
        chk("b2 fin low", b_fin, 0);
        build(32'h0000AAAA);
        n = 0;
        while (b_sal_en && n < 100) begin
            chk($sformatf("b2 bit%0d", n), b_dato_sal, n < exp_q.size() ? exp_q[n] : 1'b0);
            n++;
            if (!b_fin) b_inicio = n < 42 ? 1'b1 : 1'b0;
            tick;
        end
        chk("b2 length", n, 42);
        chk("b2 fin", b_fin, 1);
        tick;
        chk("b3 not started", b_sal_en, 0);
        chk("b3 fin low", b_fin, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
